// File: rtl/isqrt_8_bit_seq_if.sv
// Request/result bundle for the iterative 8-bit integer square-root unit.
interface isqrt_8_bit_seq_if;
  logic       start;
  logic [7:0] a;
  logic [3:0] root;
  logic [4:0] rem;
  logic       busy;
  logic       done;

  // Requester side: issues start/a, observes results and status.
  modport master (
    output start,
    output a,
    input  root,
    input  rem,
    input  busy,
    input  done
  );

  // Square-root unit side.
  modport slave (
    input  start,
    input  a,
    output root,
    output rem,
    output busy,
    output done
  );
endinterface

// File: rtl/isqrt_8_bit_seq.sv
// Iterative 8-bit integer square root: root = floor(sqrt(a)), rem = a - root^2.
// Restoring digit-by-digit algorithm, one root bit per clock, start/busy/done handshake.
module isqrt_8_bit_seq (
  input  logic               clk,
  input  logic               rst,
  isqrt_8_bit_seq_if.slave   sq
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] op_q, op_d;
  logic [3:0] q_q, q_d;
  logic [6:0] r_q, r_d;
  logic [3:0] root_q, root_d;
  logic [4:0] rem_q, rem_d;

  logic [1:0] pair;
  logic [6:0] r_sh;
  logic [6:0] trial;
  logic       fit;
  logic [6:0] r_it;
  logic [3:0] q_it;

  // One restoring iteration on the operand bit pair selected by the counter.
  always_comb begin
    pair  = op_q[{cnt_q, 1'b0} +: 2];
    r_sh  = (r_q << 2) | {5'b0, pair};
    trial = {1'b0, q_q, 2'b01};
    fit   = (r_sh >= trial);
    r_it  = fit ? (r_sh - trial) : r_sh;
    q_it  = {q_q[2:0], fit};
  end

  // Next-state and datapath control; start is only honoured while not busy.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    q_d     = q_q;
    r_d     = r_q;
    root_d  = root_q;
    rem_d   = rem_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (sq.start) begin
          state_d = StCalc;
          op_d    = sq.a;
          q_d     = 4'd0;
          r_d     = 7'd0;
          cnt_d   = 2'd3;
        end
      end
      StCalc: begin
        r_d   = r_it;
        q_d   = q_it;
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd0) begin
          state_d = StDone;
          root_d  = q_it;
          // Final remainder is at most 2*root = 30, so the top two bits are zero.
          rem_d   = r_it[4:0];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      op_q    <= 8'd0;
      q_q     <= 4'd0;
      r_q     <= 7'd0;
      root_q  <= 4'd0;
      rem_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      q_q     <= q_d;
      r_q     <= r_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
    end
  end

  assign sq.root = root_q;
  assign sq.rem  = rem_q;
  assign sq.busy = (state_q == StCalc);
  assign sq.done = (state_q == StDone);

endmodule

// File: tb/tb_isqrt_8_bit_seq.sv
// Directed self-checking bench for isqrt_8_bit_seq.
module tb_isqrt_8_bit_seq;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  isqrt_8_bit_seq_if sq ();

  isqrt_8_bit_seq dut (
    .clk (clk),
    .rst (rst),
    .sq  (sq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single pulsed start, full latency/handshake check.
  task automatic run_op(input logic [7:0] val, input int unsigned exp_root,
                        input int unsigned exp_rem);
    sq.start = 1'b1;
    sq.a     = val;
    step();                        // edge k
    sq.start = 1'b0;
    sq.a     = ~val;               // operand is latched, so this must not matter
    check("busy_k", sq.busy, 1);
    check("done_k", sq.done, 0);
    repeat (3) step();             // edges k+1..k+3
    check("busy_k3", sq.busy, 1);
    check("done_k3", sq.done, 0);
    step();                        // edge k+4
    check("done_k4", sq.done, 1);
    check("busy_k4", sq.busy, 0);
    check("root", sq.root, exp_root);
    check("rem", sq.rem, exp_rem);
    step();                        // edge k+5
    check("done_k5", sq.done, 0);
    check("busy_k5", sq.busy, 0);
  endtask

  // Start and wait for done without handshake checks; used for the sweep.
  task automatic quick_op(input logic [7:0] val);
    sq.start = 1'b1;
    sq.a     = val;
    step();
    sq.start = 1'b0;
    repeat (4) step();
    check("sweep_done", sq.done, 1);
    step();
  endtask

  initial begin
    int unsigned r;
    int unsigned m;
    errors   = 0;
    checks   = 0;
    rst      = 1'b1;
    sq.start = 1'b1;
    sq.a     = 8'hFF;

    // Reset with start asserted: nothing may happen.
    step();
    check("rst_done0", sq.done, 0);
    check("rst_busy0", sq.busy, 0);
    step();
    check("rst_done1", sq.done, 0);
    check("rst_root", sq.root, 0);
    check("rst_rem", sq.rem, 0);
    check("rst_busy1", sq.busy, 0);
    rst      = 1'b0;
    sq.start = 1'b0;
    step();
    check("post_rst_busy", sq.busy, 0);

    // Directed values.
    run_op(8'd0,   0,  0);
    run_op(8'd144, 12, 0);
    run_op(8'd200, 14, 4);
    run_op(8'd255, 15, 30);
    run_op(8'd1,   1,  0);

    // Starts during CALC are ignored.
    sq.start = 1'b1;
    sq.a     = 8'd99;
    step();                        // edge k
    sq.start = 1'b0;
    step();                        // edge k+1
    sq.start = 1'b1;
    sq.a     = 8'd16;
    step();                        // edge k+2
    step();                        // edge k+3
    check("ign_busy", sq.busy, 1);
    check("ign_done3", sq.done, 0);
    sq.start = 1'b0;
    step();                        // edge k+4
    check("ign_done4", sq.done, 1);
    check("ign_root", sq.root, 9);
    check("ign_rem", sq.rem, 18);
    step();
    check("ign_done5", sq.done, 0);
    check("ign_busy5", sq.busy, 0);
    repeat (4) step();
    check("ign_no_second", sq.done, 0);

    // Back-to-back with start held high.
    sq.start = 1'b1;
    sq.a     = 8'd50;
    step();                        // accept
    for (int rnd = 0; rnd < 3; rnd++) begin
      repeat (3) begin
        step();
        check("b2b_busy", sq.busy, 1);
        check("b2b_nodone", sq.done, 0);
      end
      step();
      check("b2b_done", sq.done, 1);
      check("b2b_busy_lo", sq.busy, 0);
      check("b2b_root", sq.root, 7);
      check("b2b_rem", sq.rem, 1);
      if (rnd == 2) sq.start = 1'b0;
      step();
      check("b2b_done_fall", sq.done, 0);
      check("b2b_rearm", sq.busy, (rnd == 2) ? 0 : 1);
    end

    // Reset mid-operation discards the computation.
    sq.start = 1'b1;
    sq.a     = 8'd225;
    step();                        // edge k
    sq.start = 1'b0;
    step();                        // edge k+1
    check("mid_root_hold", sq.root, 7);
    check("mid_rem_hold", sq.rem, 1);
    rst = 1'b1;
    step();                        // edge k+2
    check("mid_root_clr", sq.root, 0);
    check("mid_rem_clr", sq.rem, 0);
    check("mid_busy", sq.busy, 0);
    check("mid_done", sq.done, 0);
    rst = 1'b0;
    repeat (5) begin
      step();
      check("mid_no_done", sq.done, 0);
    end
    run_op(8'd225, 15, 0);

    // Exhaustive sweep: root^2 + rem == a and rem <= 2*root.
    for (int v = 0; v < 256; v++) begin
      quick_op(v[7:0]);
      r = sq.root;
      m = sq.rem;
      check("sweep_sum", r * r + m, v);
      check("sweep_bound", (m <= 2 * r) ? 1 : 0, 1);
    end

    // Loop-back of the 4-bit squarer product.
    for (int x = 0; x < 16; x++) begin
      quick_op(8'(x * x));
      check("sq_root", sq.root, x);
      check("sq_rem", sq.rem, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
